// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the fetch-sequencing logic.
//   pc_ctrl_state_t : pc_ctrl FSM encoding (run, instruction-memory wait, held redirect)
//   redirect_src_t  : which source won redirect arbitration
//   ResetPcDefault  : default for pc_ctrl's RESET_PC parameter
package cpu_pkg;

    typedef enum logic [1:0] {
        StRun          = 2'd0,
        StImemWait     = 2'd1,
        StRedirectPend = 2'd2
    } pc_ctrl_state_t;

    typedef enum logic [1:0] {
        SrcNone   = 2'd0,
        SrcBranch = 2'd1,
        SrcTrap   = 2'd2
    } redirect_src_t;

    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/redirect_sel.sv
// redirect_sel: combinational priority select among redirect sources.
// A trap beats a branch; a branch that loses in the same cycle is dropped.
// Ports:
//   br_taken, br_target : resolved branch/jump from EX
//   trap_req, trap_vec  : trap request and vector (tie low when traps are absent)
//   valid, target, src  : winning redirect, its address and its source
module redirect_sel
    import cpu_pkg::*;
(
    input  logic          br_taken,
    input  logic [31:0]   br_target,
    input  logic          trap_req,
    input  logic [31:0]   trap_vec,
    output logic          valid,
    output logic [31:0]   target,
    output redirect_src_t src
);

    always_comb begin
        valid  = 1'b0;
        target = '0;
        src    = SrcNone;
        if (trap_req) begin
            valid  = 1'b1;
            target = trap_vec;
            src    = SrcTrap;
        end else if (br_taken) begin
            valid  = 1'b1;
            target = br_target;
            src    = SrcBranch;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-sequencing controller for the program counter.
// Arbitrates redirects (EX branches/jumps, plus traps when PC_CTRL_TRAP_EN is defined),
// merges stall sources (ID load-use, instruction-memory wait) and drives the PC and
// pipeline-register flush controls. A redirect seen while a fetch is still in flight is
// held in pend_target until the fetch retires.
// Build option: define PC_CTRL_TRAP_EN to add the trap_req/trap_vec ports.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   br_taken, br_target   : taken branch/JAL/JALR from EX and its target
//   trap_req, trap_vec    : trap redirect and vector (PC_CTRL_TRAP_EN only)
//   load_use              : ID load-use hazard stall request
//   imem_ready            : current fetch completes this cycle
//   imem_req              : fetch request
//   jump_flag, next_pc    : PC load strobe and target (RESET_PC when not loading)
//   stall                 : hold PC and IF/ID
//   flush_if_id/id_ex     : bubble the IF/ID / ID/EX registers
//   imem_timeout          : sticky instruction-memory watchdog flag
module pc_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = ResetPcDefault,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
`ifdef PC_CTRL_TRAP_EN
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
`endif
    input  logic        load_use,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic        jump_flag,
    output logic [31:0] next_pc,
    output logic        stall,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        imem_timeout
);

    // Counter is at least 8 bits and always wide enough to hold TIMEOUT_CYCLES.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CntW-1:0] CntMax     = '1;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

    pc_ctrl_state_t  state_q, state_d;
    logic [31:0]     pend_target_q, pend_target_d;
    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    logic            trap_req_int;
    logic [31:0]     trap_vec_int;
    logic            sel_valid;
    logic [31:0]     sel_target;
    redirect_src_t   sel_src;
    logic [31:0]     jump_target;

`ifdef PC_CTRL_TRAP_EN
    assign trap_req_int = trap_req;
    assign trap_vec_int = trap_vec;
`else
    assign trap_req_int = 1'b0;
    assign trap_vec_int = '0;
`endif

    redirect_sel u_redirect_sel (
        .br_taken  (br_taken),
        .br_target (br_target),
        .trap_req  (trap_req_int),
        .trap_vec  (trap_vec_int),
        .valid     (sel_valid),
        .target    (sel_target),
        .src       (sel_src)
    );

    // FSM next state and fetch/PC controls.
    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        imem_req      = 1'b1;
        jump_flag     = 1'b0;
        jump_target   = '0;
        stall         = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;

        unique case (state_q)
            StRun, StImemWait: begin
                if (sel_valid) begin
                    // Redirect overrides load_use: the hazarding instruction is flushed.
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (imem_ready) begin
                        jump_flag   = 1'b1;
                        jump_target = sel_target;
                        state_d     = StRun;
                    end else begin
                        stall         = 1'b1;
                        pend_target_d = sel_target;
                        state_d       = StRedirectPend;
                    end
                end else if (!imem_ready) begin
                    stall   = 1'b1;
                    state_d = StImemWait;
                end else begin
                    stall       = load_use;
                    flush_id_ex = load_use;
                    state_d     = StRun;
                end
            end
            StRedirectPend: begin
                // EX already holds a bubble, so only a trap can replace the held target.
                if (sel_src == SrcTrap) begin
                    pend_target_d = sel_target;
                end
                if (imem_ready) begin
                    // The word returning now is wrong-path.
                    jump_flag   = 1'b1;
                    jump_target = pend_target_d;
                    flush_if_id = 1'b1;
                    state_d     = StRun;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase

        if (reset) begin
            imem_req    = 1'b0;
            jump_flag   = 1'b0;
            stall       = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end

        next_pc = jump_flag ? jump_target : RESET_PC;
    end

    // Watchdog: counts unanswered wait cycles, saturating; the flag is sticky.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (imem_ready) begin
            wd_cnt_d = '0;
        end else if (state_q != StRun) begin
            if (wd_cnt_q != CntMax) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
            if (wd_cnt_d >= TimeoutVal) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            pend_target_q <= '0;
            wd_cnt_q      <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    assign imem_timeout = timeout_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl. Expected output vectors are queued as each cycle's
// stimulus is driven and popped when the combinational outputs are sampled; a small PC
// model follows jump_flag/stall to check where the PC ends up.
module tb_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam int unsigned TMO    = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        br_taken   = 1'b0;
    logic [31:0] br_target  = '0;
    logic        load_use   = 1'b0;
    logic        imem_ready = 1'b0;
`ifdef PC_CTRL_TRAP_EN
    logic        trap_req   = 1'b0;
    logic [31:0] trap_vec   = '0;
`endif
    logic        imem_req, jump_flag, stall, flush_if_id, flush_id_ex, imem_timeout;
    logic [31:0] next_pc;

    typedef struct packed {
        logic        br;
        logic [31:0] tgt;
        logic        trap;
        logic [31:0] tv;
        logic        ld;
        logic        rdy;
    } stim_t;

    // {imem_req, jump_flag, stall, flush_if_id, flush_id_ex, next_pc}
    typedef logic [36:0] outv_t;

    outv_t       exp_q[$];
    outv_t       dut_o;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] pc_m;

    pc_ctrl #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .br_taken     (br_taken),
        .br_target    (br_target),
`ifdef PC_CTRL_TRAP_EN
        .trap_req     (trap_req),
        .trap_vec     (trap_vec),
`endif
        .load_use     (load_use),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .jump_flag    (jump_flag),
        .next_pc      (next_pc),
        .stall        (stall),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .imem_timeout (imem_timeout)
    );

    always #5 clk = ~clk;

    assign dut_o = {imem_req, jump_flag, stall, flush_if_id, flush_id_ex, next_pc};

    // PC register model fed by the controller outputs.
    always @(posedge clk or posedge reset) begin
        if (reset)          pc_m <= RST_PC;
        else if (jump_flag) pc_m <= next_pc;
        else if (!stall)    pc_m <= pc_m + 32'd4;
    end

    function automatic stim_t st(input logic br, input logic [31:0] tgt, input logic trap,
                                 input logic [31:0] tv, input logic ld, input logic rdy);
        stim_t s;
        s.br = br; s.tgt = tgt; s.trap = trap; s.tv = tv; s.ld = ld; s.rdy = rdy;
        return s;
    endfunction

    function automatic outv_t ov(input logic req, input logic jmp, input logic stl,
                                 input logic fif, input logic fex, input logic [31:0] npc);
        return {req, jmp, stl, fif, fex, npc};
    endfunction

    // Drive one cycle's inputs just after the falling edge.
    task automatic drive(input stim_t s);
        @(negedge clk);
        br_taken   = s.br;
        br_target  = s.tgt;
        load_use   = s.ld;
        imem_ready = s.rdy;
`ifdef PC_CTRL_TRAP_EN
        trap_req   = s.trap;
        trap_vec   = s.tv;
`endif
    endtask

    task automatic test_reset();
        outv_t got, want;
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h100; load_use = 1'b1; imem_ready = 1'b1;
        exp_q.push_back(ov(0, 0, 0, 0, 0, RST_PC));
        #1;
        got = dut_o; want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL reset_outputs got=%h want=%h", got, want);
        end
        total++;
        if (imem_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_timeout got=%b want=0", imem_timeout);
        end
        @(negedge clk);
        reset = 1'b0; br_taken = 1'b0; load_use = 1'b0;
        exp_q.push_back(ov(1, 0, 0, 0, 0, RST_PC));
        #1;
        got = dut_o; want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL reset_release got=%h want=%h", got, want);
        end
    endtask

    task automatic test_branch_run();
        stim_t s[2]; outv_t e[2]; outv_t got, want;
        s[0] = st(1, 32'h100, 0, 0, 0, 1); e[0] = ov(1, 1, 0, 1, 1, 32'h100);
        s[1] = st(0, 32'h0,   0, 0, 0, 1); e[1] = ov(1, 0, 0, 0, 0, RST_PC);
        for (int i = 0; i < 2; i++) begin
            drive(s[i]); exp_q.push_back(e[i]); #1;
            got = dut_o; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL branch_run[%0d] got=%h want=%h", i, got, want);
            end
            if (i == 1) begin
                total++;
                if (pc_m !== 32'h100) begin
                    bad++; $display("FAIL branch_run_pc got=%h want=%h", pc_m, 32'h100);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[2]; outv_t e[2]; outv_t got, want;
        s[0] = st(1, 32'h600, 0, 0, 0, 1); e[0] = ov(1, 1, 0, 1, 1, 32'h600);
        s[1] = st(1, 32'h700, 0, 0, 0, 1); e[1] = ov(1, 1, 0, 1, 1, 32'h700);
        for (int i = 0; i < 2; i++) begin
            drive(s[i]); exp_q.push_back(e[i]); #1;
            got = dut_o; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
            end
        end
        drive(st(0, 0, 0, 0, 0, 1)); #1;
        total++;
        if (pc_m !== 32'h700) begin
            bad++; $display("FAIL back_to_back_pc got=%h want=%h", pc_m, 32'h700);
        end
    endtask

    task automatic test_held_redirect();
        stim_t s[4]; outv_t e[4]; outv_t got, want;
        s[0] = st(1, 32'h200, 0, 0, 0, 0); e[0] = ov(1, 0, 1, 1, 1, RST_PC);
        s[1] = st(1, 32'h999, 0, 0, 0, 0); e[1] = ov(1, 0, 1, 0, 0, RST_PC);
        s[2] = st(0, 32'h0,   0, 0, 1, 0); e[2] = ov(1, 0, 1, 0, 0, RST_PC);
        s[3] = st(0, 32'h0,   0, 0, 0, 1); e[3] = ov(1, 1, 0, 1, 0, 32'h200);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]); exp_q.push_back(e[i]); #1;
            got = dut_o; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL held_redirect[%0d] got=%h want=%h", i, got, want);
            end
        end
        drive(st(0, 0, 0, 0, 0, 1)); #1;
        total++;
        if (pc_m !== 32'h200) begin
            bad++; $display("FAIL held_redirect_pc got=%h want=%h", pc_m, 32'h200);
        end
    endtask

    task automatic test_load_use();
        outv_t got, want;
        logic [31:0] pc_before;
        drive(st(0, 0, 0, 0, 1, 1));
        exp_q.push_back(ov(1, 0, 1, 0, 1, RST_PC)); #1;
        pc_before = pc_m;
        got = dut_o; want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL load_use got=%h want=%h", got, want);
        end
        drive(st(1, 32'h300, 0, 0, 1, 1));
        exp_q.push_back(ov(1, 1, 0, 1, 1, 32'h300)); #1;
        total++;
        if (pc_m !== pc_before) begin
            bad++; $display("FAIL load_use_pc_hold got=%h want=%h", pc_m, pc_before);
        end
        got = dut_o; want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL load_use_redirect got=%h want=%h", got, want);
        end
        drive(st(0, 0, 0, 0, 0, 1)); #1;
        total++;
        if (pc_m !== 32'h300) begin
            bad++; $display("FAIL load_use_pc got=%h want=%h", pc_m, 32'h300);
        end
    endtask

    task automatic test_imem_wait();
        stim_t s[8]; outv_t e[8]; outv_t got, want;
        s[0] = st(0, 32'h0,   0, 0, 0, 0); e[0] = ov(1, 0, 1, 0, 0, RST_PC);
        s[1] = st(0, 32'h0,   0, 0, 1, 0); e[1] = ov(1, 0, 1, 0, 0, RST_PC);
        s[2] = st(0, 32'h0,   0, 0, 1, 1); e[2] = ov(1, 0, 1, 0, 1, RST_PC);
        s[3] = st(0, 32'h0,   0, 0, 0, 0); e[3] = ov(1, 0, 1, 0, 0, RST_PC);
        s[4] = st(1, 32'h400, 0, 0, 0, 0); e[4] = ov(1, 0, 1, 1, 1, RST_PC);
        s[5] = st(0, 32'h0,   0, 0, 0, 1); e[5] = ov(1, 1, 0, 1, 0, 32'h400);
        s[6] = st(0, 32'h0,   0, 0, 0, 0); e[6] = ov(1, 0, 1, 0, 0, RST_PC);
        s[7] = st(1, 32'h480, 0, 0, 1, 1); e[7] = ov(1, 1, 0, 1, 1, 32'h480);
        for (int i = 0; i < 8; i++) begin
            drive(s[i]); exp_q.push_back(e[i]); #1;
            got = dut_o; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL imem_wait[%0d] got=%h want=%h", i, got, want);
            end
        end
        drive(st(0, 0, 0, 0, 0, 1)); #1;
        total++;
        if (pc_m !== 32'h480) begin
            bad++; $display("FAIL imem_wait_pc got=%h want=%h", pc_m, 32'h480);
        end
    endtask

`ifdef PC_CTRL_TRAP_EN
    task automatic test_trap();
        stim_t s[4]; outv_t e[4]; outv_t got, want;
        s[0] = st(1, 32'h300, 1, 32'h80, 0, 1); e[0] = ov(1, 1, 0, 1, 1, 32'h80);
        s[1] = st(1, 32'h300, 0, 32'h0,  0, 0); e[1] = ov(1, 0, 1, 1, 1, RST_PC);
        s[2] = st(1, 32'h999, 1, 32'h80, 0, 0); e[2] = ov(1, 0, 1, 0, 0, RST_PC);
        s[3] = st(0, 32'h0,   0, 32'h0,  0, 1); e[3] = ov(1, 1, 0, 1, 0, 32'h80);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]); exp_q.push_back(e[i]); #1;
            got = dut_o; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL trap[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask
`endif

    task automatic test_watchdog();
        for (int k = 0; k < 6; k++) begin
            drive(st(0, 0, 0, 0, 0, 0)); #1;
            total++;
            if (imem_timeout !== (k == 5)) begin
                bad++; $display("FAIL watchdog[%0d] got=%b want=%b", k, imem_timeout, (k == 5));
            end
        end
        for (int k = 0; k < 2; k++) begin
            drive(st(0, 0, 0, 0, 0, 1)); #1;
            total++;
            if (imem_timeout !== 1'b1) begin
                bad++; $display("FAIL watchdog_sticky[%0d] got=%b want=1", k, imem_timeout);
            end
        end
    endtask

    task automatic test_reset_pend();
        outv_t got, want;
        drive(st(1, 32'h500, 0, 0, 0, 0));
        exp_q.push_back(ov(1, 0, 1, 1, 1, RST_PC)); #1;
        got = dut_o; want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL reset_pend_enter got=%h want=%h", got, want);
        end
        drive(st(0, 0, 0, 0, 0, 0));
        #2 reset = 1'b1;
        exp_q.push_back(ov(0, 0, 0, 0, 0, RST_PC)); #1;
        got = dut_o; want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL reset_pend_outputs got=%h want=%h", got, want);
        end
        total++;
        if (imem_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_pend_timeout got=%b want=0", imem_timeout);
        end
        #1 reset = 1'b0;
        drive(st(0, 0, 0, 0, 0, 1));
        exp_q.push_back(ov(1, 0, 0, 0, 0, RST_PC)); #1;
        got = dut_o; want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL reset_pend_release got=%h want=%h", got, want);
        end
        drive(st(0, 0, 0, 0, 0, 1)); #1;
        total++;
        if (pc_m !== RST_PC + 32'd4) begin
            bad++; $display("FAIL reset_pend_pc got=%h want=%h", pc_m, RST_PC + 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_branch_run();
        test_back_to_back();
        test_held_redirect();
        test_load_use();
        test_imem_wait();
`ifdef PC_CTRL_TRAP_EN
        test_trap();
`endif
        test_watchdog();
        test_reset_pend();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-sequencing controller for the program counter register. It arbitrates the redirect sources: resolved branches and jumps from EX, plus traps when the trap feature is compiled in. It also merges the stall sources: load-use hazards from ID and instruction-memory wait. From these it drives the PC's `jump_flag`, `stall` and `next_pc` inputs, and the IF/ID and ID/EX pipeline-register flushes. A redirect that arrives while an instruction fetch is in flight is held until the fetch retires.

## Interface
- `RESET_PC`, default 32'h0000_0000: value of `next_pc` while no redirect is pending.
- `TIMEOUT_CYCLES`, default 255: number of consecutive wait cycles after which `imem_timeout` sets.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `br_taken` in 1: EX reports a taken branch, JAL or JALR this cycle.
- `br_target` in 32: target address for `br_taken`.
- `trap_req` in 1: trap redirect request (`PC_CTRL_TRAP_EN` only).
- `trap_vec` in 32: trap target address (`PC_CTRL_TRAP_EN` only).
- `load_use` in 1: ID hazard request to stall.
- `imem_ready` in 1: the current fetch completes this cycle.
- `imem_req` out 1: fetch request.
- `jump_flag` out 1: to PC; load `next_pc`.
- `next_pc` out 32: redirect target to PC.
- `stall` out 1: to PC and IF/ID; hold.
- `flush_if_id` out 1: bubble the IF/ID register.
- `flush_id_ex` out 1: bubble the ID/EX register.
- `imem_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states: RUN, IMEM_WAIT, REDIRECT_PEND. State encoding comes from the shared package.
- Redirect selection: `trap_req` has priority over `br_taken`. The selected target is `trap_vec` or `br_target`.
- RUN
  - `imem_req` = 1.
  - Redirect with `imem_ready` = 1: `jump_flag` = 1, `next_pc` = target, `flush_if_id` = `flush_id_ex` = 1, `stall` = 0. State stays RUN.
  - Redirect with `imem_ready` = 0: capture the target into `pend_target`. Assert both flushes, `stall` = 1, `jump_flag` = 0. Go to REDIRECT_PEND.
  - No redirect, `imem_ready` = 0: `stall` = 1. Go to IMEM_WAIT.
  - No redirect, `imem_ready` = 1: `stall` = `load_use`. When `load_use` = 1, also `flush_id_ex` = 1.
- IMEM_WAIT
  - `stall` = 1 and the wait counter increments.
  - `imem_ready` = 1 with no redirect: return to RUN and apply the RUN non-redirect rules in that cycle.
  - A redirect is handled exactly as in RUN, with `imem_ready` deciding between an immediate redirect and REDIRECT_PEND.
- REDIRECT_PEND
  - `stall` = 1.
  - `br_taken` is ignored, because EX already holds a bubble.
  - `trap_req` overwrites `pend_target`.
  - The cycle `imem_ready` = 1: `jump_flag` = 1, `next_pc` = `pend_target`, `flush_if_id` = 1 (the returning word is wrong-path). Go to RUN.
- A redirect always overrides `load_use`, because the hazarding instruction is flushed.
- `next_pc` = `RESET_PC` whenever `jump_flag` = 0.
- Watchdog counter
  - 8 bits wide minimum, saturating.
  - Counts cycles spent in IMEM_WAIT or REDIRECT_PEND with `imem_ready` = 0.
  - Clears on any cycle with `imem_ready` = 1.
  - Reaching `TIMEOUT_CYCLES` sets `imem_timeout`, which stays set until `reset`.

## Timing
- `jump_flag`, `next_pc`, `stall`, flushes and `imem_req` are combinational from state and inputs. The PC samples them at the next rising edge.
- Redirect latency: a same-cycle redirect updates the PC one edge after `br_taken`. A held redirect updates the PC one edge after `imem_ready`.
- Reset is asynchronous:
  - state = RUN, `pend_target` = 0, counter = 0, `imem_timeout` = 0.
  - While `reset` is high, all outputs are 0 and `next_pc` = `RESET_PC`.
- Reset mid-REDIRECT_PEND discards the pending target.
- `trap_req` and `br_taken` asserted in the same cycle: the trap wins and the branch is dropped.

## Configuration
- `PC_CTRL_TRAP_EN` defined: the `trap_req` and `trap_vec` ports exist, and traps are the highest-priority redirect, including overwrite in REDIRECT_PEND.
- `PC_CTRL_TRAP_EN` undefined: the ports are absent and `br_taken` is the only redirect source.

## Structure
- Shared package `cpu_pkg` holds:
  - the `pc_ctrl_state_t` enum (RUN, IMEM_WAIT, REDIRECT_PEND);
  - the `RESET_PC` default;
  - the redirect-source enum (NONE, BRANCH, TRAP).
- One sub-module, `redirect_sel`: combinational priority select producing a valid/target pair. The FSM, `pend_target` register and watchdog stay in `pc_ctrl`.

## Test plan
- Branch in RUN: `br_taken` = 1, `br_target` = 32'h100, `imem_ready` = 1 → same cycle `jump_flag` = 1, `next_pc` = 32'h100, both flushes = 1. PC = 32'h100 after the edge.
- Held redirect: `br_taken` with `br_target` = 32'h200 while `imem_ready` = 0 for 3 cycles → `stall` = 1 for those cycles, `jump_flag` = 0. The cycle `imem_ready` rises: `jump_flag` = 1, `next_pc` = 32'h200, `flush_if_id` = 1.
- Load-use: `load_use` = 1, `imem_ready` = 1, no redirect → `stall` = 1, `flush_id_ex` = 1, PC unchanged. `load_use` plus `br_taken` together → redirect only, `stall` = 0.
- Trap priority (`PC_CTRL_TRAP_EN`): `trap_req` with `trap_vec` = 32'h80 and `br_taken` with 32'h300 in the same cycle → `next_pc` = 32'h80. A trap arriving in REDIRECT_PEND replaces the held 32'h300.
- Watchdog: `TIMEOUT_CYCLES` = 4, `imem_ready` held 0 → `imem_timeout` = 1 after the 4th wait cycle, and it stays 1 after `imem_ready` returns.
- Async reset asserted in REDIRECT_PEND mid-cycle → outputs drop to 0 immediately. After release: RUN, no `jump_flag`, PC flows from `RESET_PC`.
